// File: rtl/tx_byte_serialiser.sv
// Byte-to-bit Tx serialiser: LSB-first bit stream with optional odd parity per full byte,
// prefetching the next upstream byte into a holding register so bytes follow back to back.
module tx_byte_serialiser #(
  parameter bit ADD_PARITY   = 1'b1,
  parameter int SETTLE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_data_valid,
  input  logic [2:0] in_data_bits,
  output logic       in_req,
  output logic       out_data,
  output logic       out_data_valid,
  output logic       out_last_bit_in_byte,
  input  logic       out_req
);

  localparam int SW = (SETTLE_TICKS < 2) ? 1 : $clog2(SETTLE_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t          state_r;
  logic [6:0]      shift_r;
  logic [3:0]      count_r;
  logic            par_inc_r;
  logic            par_bit_r;
  logic [7:0]      hold_data_r;
  logic [2:0]      hold_bits_r;
  logic            hold_valid_r;
  logic [SW-1:0]   settle_r;
  logic            settle_active_r;
  logic            in_req_r;
  logic            out_data_r;
  logic            out_valid_r;
  logic            out_last_r;

  logic            advance_s;
  logic            do_load_s;
  logic [7:0]      load_data_s;
  logic [2:0]      load_bits_s;
  logic [3:0]      load_n_s;
  logic            load_par_s;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic logic [3:0] bit_count(input logic [2:0] b);
    return (b == 3'd0) ? 4'd8 : {1'b0, b};
  endfunction

  assign in_req               = in_req_r;
  assign out_data             = out_data_r;
  assign out_data_valid       = out_valid_r;
  assign out_last_bit_in_byte = out_last_r;

  // Byte-completion detection and selection of the byte to load (fresh input in IDLE, holding register otherwise)
  always_comb begin
    advance_s = 1'b0;
    if (state_r == PARITY) begin
      advance_s = out_req;
    end else if (state_r == DATA) begin
      advance_s = out_req && (count_r == 4'd1) && !par_inc_r;
    end else begin
      advance_s = 1'b0;
    end
    // A running settle window in IDLE means the inputs are not yet trustworthy
    if (state_r == IDLE) begin
      load_data_s = in_data;
      load_bits_s = in_data_bits;
      do_load_s   = in_data_valid && !settle_active_r;
    end else begin
      load_data_s = hold_data_r;
      load_bits_s = hold_bits_r;
      do_load_s   = advance_s && hold_valid_r;
    end
    load_n_s   = bit_count(load_bits_s);
    load_par_s = ADD_PARITY && (load_n_s == 4'd8);
  end

  // Serialiser FSM with settle-delayed prefetch and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      shift_r         <= 7'd0;
      count_r         <= 4'd0;
      par_inc_r       <= 1'b0;
      par_bit_r       <= 1'b0;
      hold_data_r     <= 8'd0;
      hold_bits_r     <= 3'd0;
      hold_valid_r    <= 1'b0;
      settle_r        <= '0;
      settle_active_r <= 1'b0;
      in_req_r        <= 1'b0;
      out_data_r      <= 1'b0;
      out_valid_r     <= 1'b0;
      out_last_r      <= 1'b0;
    end else begin
      in_req_r <= 1'b0;

      if (settle_active_r) begin
        if (settle_r == '0) begin
          settle_active_r <= 1'b0;
          if (in_data_valid) begin
            hold_data_r  <= in_data;
            hold_bits_r  <= in_data_bits;
            hold_valid_r <= 1'b1;
          end
        end else begin
          settle_r <= settle_r - SW'(1);
        end
      end

      if (do_load_s) begin
        state_r         <= DATA;
        shift_r         <= load_data_s[7:1];
        count_r         <= load_n_s;
        par_inc_r       <= load_par_s;
        par_bit_r       <= odd_parity(load_data_s);
        hold_valid_r    <= 1'b0;
        in_req_r        <= 1'b1;
        settle_r        <= SW'(SETTLE_TICKS);
        settle_active_r <= 1'b1;
        out_data_r      <= load_data_s[0];
        out_valid_r     <= 1'b1;
        out_last_r      <= (load_n_s == 4'd1) && !load_par_s;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          DATA: begin
            if (out_req) begin
              if (count_r > 4'd1) begin
                shift_r    <= shift_r >> 1;
                count_r    <= count_r - 4'd1;
                out_data_r <= shift_r[0];
                out_last_r <= (count_r == 4'd2) && !par_inc_r;
              end else if (par_inc_r) begin
                state_r    <= PARITY;
                out_data_r <= par_bit_r;
                out_last_r <= 1'b1;
              end else begin
                state_r     <= IDLE;
                out_data_r  <= 1'b0;
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
              end
            end
          end
          PARITY: begin
            if (out_req) begin
              state_r     <= IDLE;
              out_data_r  <= 1'b0;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
            end
          end
          default: begin
            state_r     <= IDLE;
            out_data_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_byte_serialiser.sv
// Directed bench for tx_byte_serialiser: an upstream byte source and a paced downstream
// consumer, with expected bits queued per frame and popped as each bit is consumed.
module tb_tx_byte_serialiser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic [2:0] in_bits;
  logic       in_valid;
  logic       out_req;
  logic       sel;

  logic p_req, p_d, p_v, p_l;
  logic n_req, n_d, n_v, n_l;
  logic o_req, o_d, o_v, o_l;

  always #5 clk = ~clk;

  tx_byte_serialiser #(.ADD_PARITY(1'b1), .SETTLE_TICKS(4)) dut_p (
    .clk(clk), .rst(rst), .in_data(in_data), .in_data_valid(in_valid & ~sel),
    .in_data_bits(in_bits), .in_req(p_req), .out_data(p_d), .out_data_valid(p_v),
    .out_last_bit_in_byte(p_l), .out_req(out_req & ~sel)
  );

  tx_byte_serialiser #(.ADD_PARITY(1'b0), .SETTLE_TICKS(4)) dut_np (
    .clk(clk), .rst(rst), .in_data(in_data), .in_data_valid(in_valid & sel),
    .in_data_bits(in_bits), .in_req(n_req), .out_data(n_d), .out_data_valid(n_v),
    .out_last_bit_in_byte(n_l), .out_req(out_req & sel)
  );

  assign o_req = sel ? n_req : p_req;
  assign o_d   = sel ? n_d   : p_d;
  assign o_v   = sel ? n_v   : p_v;
  assign o_l   = sel ? n_l   : p_l;

  typedef struct packed {
    logic d;
    logic l;
  } bit_t;

  bit_t       exp_q[$];
  logic [7:0] f_data[$];
  logic [2:0] f_bits[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic [7:0] d, input logic [2:0] b, input logic par_en);
    int   n;
    logic par;
    n   = (b == 3'd0) ? 8 : int'(b);
    par = par_en && (n == 8);
    for (int i = 0; i < n; i++) exp_q.push_back('{d: d[i], l: (i == n - 1) && !par});
    if (par) exp_q.push_back('{d: ($countones(d) % 2 == 0), l: 1'b1});
  endtask

  task automatic present(input int idx);
    if (idx < f_data.size()) begin
      in_data  = f_data[idx];
      in_bits  = f_bits[idx];
      in_valid = 1'b1;
    end else begin
      in_data  = 8'h3C;
      in_bits  = 3'd0;
      in_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input int period, input int abort_after);
    int   idx, reqs, popped, t, lag, budget;
    bit   started, gap, dbl, prev_req, done;
    bit_t e;
    exp_q.delete();
    foreach (f_data[i]) push_expected(f_data[i], f_bits[i], ~sel);
    budget = (exp_q.size() + 4) * (period + 2) + 50;
    idx = 0; reqs = 0; popped = 0; t = 0; lag = 0;
    started = 0; gap = 0; dbl = 0; prev_req = 0; done = 0;
    @(negedge clk);
    out_req = 1'b0;
    present(0);
    @(negedge clk);
    check($sformatf("%s/first_valid", tag), o_v, 1);
    check($sformatf("%s/first_req", tag), o_req, 1);
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      out_req = 1'b0;
      if (lag > 0) begin
        lag--;
        if (lag == 0) present(idx);
      end
      if (o_req) begin
        if (prev_req) dbl = 1;
        reqs++;
        idx++;
        in_data  = 8'hEE ^ 8'(idx);
        in_bits  = 3'd5;
        in_valid = 1'b1;
        lag      = 2;
      end
      prev_req = o_req;
      if (abort_after > 0 && popped == abort_after && t == 3) begin
        #2 rst = 1'b1;
        #1 check($sformatf("%s/async_rst", tag), {o_req, o_v, o_d, o_l}, 4'b0000);
        exp_q.delete();
        in_valid = 1'b0;
        done = 1;
      end else if (exp_q.size() == 0) begin
        check($sformatf("%s/end_idle", tag), {o_v, o_d, o_l}, 3'b000);
        done = 1;
      end else if (o_v) begin
        started = 1;
        t++;
        if (t >= period) begin
          e = exp_q.pop_front();
          check($sformatf("%s/bit%0d", tag, popped), o_d, e.d);
          check($sformatf("%s/last%0d", tag, popped), o_l, e.l);
          out_req = 1'b1;
          t = 0;
          popped++;
        end
      end else if (started) begin
        gap = 1;
      end
    end
    check($sformatf("%s/completed", tag), done, 1);
    if (abort_after == 0) begin
      check($sformatf("%s/in_req_count", tag), reqs, f_data.size());
      check($sformatf("%s/valid_gap", tag), gap, 0);
      check($sformatf("%s/in_req_width", tag), dbl, 0);
    end
    out_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_req = 1'b0; sel = 1'b0;
    in_data = 8'h00; in_bits = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset_p", {p_req, p_v, p_d, p_l}, 4'b0000);
    check("reset_np", {n_req, n_v, n_d, n_l}, 4'b0000);
    rst = 1'b0;

    f_data = {8'h5A}; f_bits = {3'd0};
    run_frame("byte_5a", 128, 0);

    f_data = {8'h26}; f_bits = {3'd7};
    run_frame("short_26", 10, 0);

    f_data = {8'h93, 8'h20}; f_bits = {3'd0, 3'd0};
    run_frame("two_byte", 10, 0);

    sel = 1'b1;
    f_data = {8'hFF}; f_bits = {3'd0};
    run_frame("nopar_ff", 10, 0);
    sel = 1'b0;

    f_data = {8'hA5, 8'h5A}; f_bits = {3'd0, 3'd0};
    run_frame("rst_a5", 10, 3);
    @(negedge clk);
    @(negedge clk);
    check("rst_held", {p_req, p_v, p_d, p_l}, 4'b0000);
    rst = 1'b0;

    f_data = {8'h01}; f_bits = {3'd0};
    run_frame("after_rst_01", 10, 0);

    f_data = {8'hC3, 8'h7E, 8'h81}; f_bits = {3'd3, 3'd0, 3'd1};
    run_frame("mixed", 8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
